// File: rtl/key_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// key_cond_pkg : shared sizing helper and SLC-3 channel indices
// Revision     : 1.0
// ============================================================================
package key_cond_pkg;

    localparam int KEY_RUN      = 0;
    localparam int KEY_CONTINUE = 1;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : key_cond_pkg
`default_nettype wire

// File: rtl/key_conditioner_channel.sv
`default_nettype none
// ============================================================================
// key_channel : one push-button channel (sync, debounce, strobes, auto-repeat)
// Revision    : 1.0
// ============================================================================
module key_channel
    import key_cond_pkg::*;
#(
    parameter int DB_CYCLES    = 16,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int              CNT_W    = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic [CNT_W-1:0] r_cnt;
    logic             w_p;
    logic             w_differ;
    logic             w_accept;

    assign w_p      = r_s2 ^ ACTIVE_LOW;
    assign w_differ = (w_p != r_level);
    assign w_accept = w_differ && (r_cnt == CNT_LAST);

    // Synchroniser resets to the released pin value so reset exit looks idle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_s1      <= ACTIVE_LOW;
            r_s2      <= ACTIVE_LOW;
            r_level   <= 1'b0;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_s1      <= i_raw;
            r_s2      <= r_s1;
            r_press   <= w_accept && w_p;
            r_release <= w_accept && !w_p;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= w_p;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

    generate
        if (REPEAT_DELAY > 0) begin : g_repeat
            localparam int RC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
            localparam int RC_W   = cnt_width(RC_MAX);
            localparam logic [RC_W-1:0] RC_FIRST_LAST = RC_W'(REPEAT_DELAY - 1);
            localparam logic [RC_W-1:0] RC_RATE_LAST  = RC_W'(REPEAT_RATE - 1);

            logic [RC_W-1:0] r_rc;
            logic            r_first;
            logic            r_repeat;
            logic            w_hit;

            assign w_hit = (r_rc == (r_first ? RC_FIRST_LAST : RC_RATE_LAST));

            // Any level acceptance restarts the schedule, so a release can never repeat.
            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset) begin
                    r_rc     <= '0;
                    r_first  <= 1'b0;
                    r_repeat <= 1'b0;
                end else if (w_accept) begin
                    r_rc     <= '0;
                    r_first  <= 1'b1;
                    r_repeat <= 1'b0;
                end else if (r_level) begin
                    if (w_hit) begin
                        r_rc     <= '0;
                        r_first  <= 1'b0;
                        r_repeat <= 1'b1;
                    end else begin
                        r_rc     <= r_rc + 1'b1;
                        r_repeat <= 1'b0;
                    end
                end else begin
                    r_rc     <= '0;
                    r_repeat <= 1'b0;
                end
            end

            assign o_repeat = r_repeat;
        end else begin : g_no_repeat
            assign o_repeat = 1'b0;
        end
    endgenerate

endmodule : key_channel
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// key_conditioner : N independent debounced key channels with strobes
// Revision        : 1.0
// ============================================================================
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int N_KEYS       = 2,
    parameter int DB_CYCLES    = 16,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [N_KEYS-1:0] Key_raw,
    output logic [N_KEYS-1:0] Key_level,
    output logic [N_KEYS-1:0] Key_press,
    output logic [N_KEYS-1:0] Key_release,
    output logic [N_KEYS-1:0] Key_repeat
);

    generate
        for (genvar g = 0; g < N_KEYS; g++) begin : g_keys
            key_channel #(
                .DB_CYCLES    (DB_CYCLES),
                .ACTIVE_LOW   (ACTIVE_LOW),
                .REPEAT_DELAY (REPEAT_DELAY),
                .REPEAT_RATE  (REPEAT_RATE)
            ) u_channel (
                .Clk       (Clk),
                .Reset     (Reset),
                .i_raw     (Key_raw[g]),
                .o_level   (Key_level[g]),
                .o_press   (Key_press[g]),
                .o_release (Key_release[g]),
                .o_repeat  (Key_repeat[g])
            );
        end
    endgenerate

endmodule : key_conditioner
`default_nettype wire
